qupls_extract_ins_q: RTL

- Parametrised next-generation instruction extractor for the Qupls front end. It sits between the I-cache line/PC-group stage and the decode/rename stage.
- Slices NLANE instructions per fetch group out of an I-cache line, or substitutes micro-code instructions.
- Injects a hardware-interrupt SYS instruction exactly once per request, truncates the group after the first BSR, and masks lanes older than a branch-miss target.
- Buffers extracted groups in a DEPTH-entry FIFO with valid/ready handshakes on both sides, so decode stalls no longer require a global enable.

---
 rtl/qupls_extract_ins_q_pkg.sv | 49 ++++
 rtl/qupls_extract_lane.sv | 29 ++
 rtl/qupls_extract_ins_q.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/qupls_extract_ins_q_pkg.sv
// Shared Qupls front-end types: instruction, PC, and extracted fetch group.
// Latency: none (types and a pure decode helper only).
// Backpressure: not applicable.
package QuplsPkg;

   localparam int QP_NLANE = 4;
   localparam int QP_INSW  = 40;

   typedef logic [31:0] pc_address_t;
   typedef logic [5:0]  aregno_t;

   // Instruction as handed to decode: raw bits plus pre-decoded register fields.
   typedef struct packed {
      aregno_t              aRt;
      aregno_t              aRa;
      aregno_t              aRb;
      aregno_t              aRc;
      logic                 pred_btst;
      logic [QP_INSW-1:0]   ins;
   } ex_instruction_t;

   localparam logic [6:0] OP_SYS = 7'h07;
   localparam logic [6:0] OP_NOP = 7'h0B;
   localparam logic [6:0] OP_BSR = 7'h21;
   localparam logic [6:0] FN_IRQ = 7'h13;

   // One fetch group as stored in the output FIFO.
   typedef struct packed {
      ex_instruction_t [QP_NLANE-1:0] ins;
      pc_address_t     [QP_NLANE-1:0] pc;
      logic            [QP_NLANE-1:0] lane_v;
      logic                           do_bsr;
      pc_address_t                    bsr_tgt;
   } extract_grp_t;

   // Register fields are 3-bit slots in the raw word, widened to arch register numbers.
   function automatic ex_instruction_t decode_ex(input logic [QP_INSW-1:0] ins);
      ex_instruction_t ex;
      ex           = '0;
      ex.ins       = ins;
      ex.aRt       = aregno_t'(ins[9:7]);
      ex.aRa       = aregno_t'(ins[12:10]);
      ex.aRb       = aregno_t'(ins[15:13]);
      ex.aRc       = aregno_t'(ins[18:16]);
      ex.pred_btst = 1'b0;
      return ex;
   endfunction

endpackage

// File: rtl/qupls_extract_lane.sv
// One extraction lane: byte-offset slice of the cache line or micro-code word, plus BSR decode.
// Latency: combinational.
// Backpressure: none; the parent gates acceptance.
module qupls_extract_lane
   import QuplsPkg::*;
#(
   parameter int INSW  = QP_INSW,
   parameter int LINEW = 1024
)(
   input  logic [LINEW-1:0] line_i,
   input  pc_address_t      pc_i,
   input  logic             mipv_i,
   input  ex_instruction_t  mc_ins_i,
   output ex_instruction_t  ins_o,
   output logic             is_bsr_o,
   output pc_address_t      bsr_tgt_o
);

   logic [INSW-1:0]        raw;
   logic signed [INSW-14:0] disp;

   // Low six PC bits select the starting byte within the line.
   assign raw       = line_i[{pc_i[5:0], 3'b000} +: INSW];
   assign ins_o     = mipv_i ? mc_ins_i : decode_ex(raw);
   assign is_bsr_o  = (ins_o.ins[6:0] == OP_BSR);
   assign disp      = ins_o.ins[INSW-1:13];
   assign bsr_tgt_o = pc_i + pc_address_t'(disp);

endmodule

// File: rtl/qupls_extract_ins_q.sv
// Extracts NLANE instructions per fetch group (with IRQ injection, BSR cut, miss masking) into a FIFO.
// Latency: 1 cycle from accept to out_valid_o when the FIFO was empty.
// Backpressure: in_ready_o drops when the DEPTH-entry FIFO is full; out_ready_i pops the head.
module qupls_extract_ins_q
   import QuplsPkg::*;
#(
   parameter int NLANE = QP_NLANE,
   parameter int INSW  = QP_INSW,
   parameter int LINEW = 1024,
   parameter int DEPTH = 4
)(
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   in_valid_i,
   output logic                                   in_ready_o,
   input  logic [LINEW-1:0]                       line_i,
   input  logic [NLANE*$bits(pc_address_t)-1:0]   pc_i,
   input  logic                                   mipv_i,
   input  logic [NLANE*$bits(ex_instruction_t)-1:0] mc_ins_i,
   input  logic                                   hirq_i,
   input  logic [2:0]                             irq_i,
   input  logic [8:0]                             vect_i,
   input  logic                                   branchmiss_i,
   input  pc_address_t                            misspc_i,
   output logic                                   out_valid_o,
   input  logic                                   out_ready_i,
   output logic [NLANE*$bits(ex_instruction_t)-1:0] ins_o,
   output logic [NLANE*$bits(pc_address_t)-1:0]   pc_o,
   output logic [NLANE-1:0]                       lane_v_o,
   output logic                                   do_bsr_o,
   output pc_address_t                            bsr_tgt_o,
   output logic                                   irq_taken_o
);

   localparam int PCW = $bits(pc_address_t);
   localparam int EXW = $bits(ex_instruction_t);
   localparam int AW  = $clog2(DEPTH);

   localparam logic [0:0] IRQ_IDLE = 1'b0;
   localparam logic [0:0] IRQ_HELD = 1'b1;

   ex_instruction_t lane_ins [NLANE];
   logic            lane_bsr [NLANE];
   pc_address_t     lane_tgt [NLANE];

   extract_grp_t    grp_d;
   extract_grp_t    head;
   extract_grp_t    mem [DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic [0:0]      irq_st;
   logic            full, accept, inject, bsr_seen;

   for (genvar k = 0; k < NLANE; k++) begin : g_lane
      qupls_extract_lane #(.INSW(INSW), .LINEW(LINEW)) u_lane (
         .line_i    (line_i),
         .pc_i      (pc_i[k*PCW +: PCW]),
         .mipv_i    (mipv_i),
         .mc_ins_i  (mc_ins_i[k*EXW +: EXW]),
         .ins_o     (lane_ins[k]),
         .is_bsr_o  (lane_bsr[k]),
         .bsr_tgt_o (lane_tgt[k])
      );
   end

   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign in_ready_o = rst_i & ~full;
   assign accept     = in_valid_i & in_ready_o;
   // Interrupt injection waits for micro-code to finish and fires once per request.
   assign inject     = (irq_st == IRQ_IDLE) & hirq_i & ~mipv_i;

   // Assemble the candidate group: normal lanes cut after the first BSR, or the IRQ group.
   always_comb begin
      grp_d    = '0;
      bsr_seen = 1'b0;
      for (int k = 0; k < NLANE; k++) begin
         grp_d.ins[k]    = lane_ins[k];
         grp_d.pc[k]     = pc_i[k*PCW +: PCW];
         grp_d.lane_v[k] = ~bsr_seen;
         if (!bsr_seen && lane_bsr[k]) begin
            bsr_seen      = 1'b1;
            grp_d.do_bsr  = 1'b1;
            grp_d.bsr_tgt = lane_tgt[k];
         end
      end
      if (!bsr_seen)
         grp_d.bsr_tgt = pc_i[(NLANE-1)*PCW +: PCW] + PCW'(INSW/8);
      if (inject) begin
         grp_d = '0;
         for (int k = 0; k < NLANE; k++) begin
            grp_d.ins[k] = decode_ex(QP_INSW'(OP_NOP));
            grp_d.pc[k]  = pc_i[PCW-1:0];
         end
         grp_d.ins[0]  = decode_ex(QP_INSW'({FN_IRQ, vect_i, irq_i, OP_SYS}));
         grp_d.lane_v  = QP_NLANE'(1);
         grp_d.bsr_tgt = pc_i[PCW-1:0];
      end
      // Lanes before the miss target belong to the wrong path.
      for (int k = 0; k < NLANE; k++)
         if (branchmiss_i && (misspc_i > grp_d.pc[k]))
            grp_d.lane_v[k] = 1'b0;
   end

   // IRQ request tracking and the one-cycle taken pulse.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         irq_st      <= IRQ_IDLE;
         irq_taken_o <= 1'b0;
      end else begin
         irq_taken_o <= accept & inject;
         if (accept && inject)
            irq_st <= IRQ_HELD;
         else if (irq_st == IRQ_HELD && !hirq_i)
            irq_st <= IRQ_IDLE;
      end
   end

   // FIFO storage and pointers; a branch miss discards everything older than this cycle's push.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (accept) begin
            mem[wr_ptr[AW-1:0]] <= grp_d;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (branchmiss_i)
            rd_ptr <= wr_ptr;
         else if (out_valid_o && out_ready_i)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign head        = mem[rd_ptr[AW-1:0]];
   assign out_valid_o = (wr_ptr != rd_ptr);
   assign ins_o       = head.ins;
   assign pc_o        = head.pc;
   assign lane_v_o    = head.lane_v;
   assign do_bsr_o    = head.do_bsr;
   assign bsr_tgt_o   = head.bsr_tgt;

endmodule
